// File: rtl/perf_counter_bank_pkg.sv
// Shared types, constants and helpers for the performance-counter bank.
// Channel indices name the CPU event sources feeding the bank.
package perf_counter_bank_pkg;

  localparam int PERF_NUM_CNT   = 9;
  localparam int PERF_CNT_WIDTH = 16;
  localparam int PERF_IDX_WIDTH = 4;

  typedef logic [PERF_IDX_WIDTH-1:0] perf_cnt_idx_t;

  typedef enum logic [PERF_IDX_WIDTH-1:0] {
    PERF_L2HIT   = 4'd0,
    PERF_L2MISS  = 4'd1,
    PERF_DL1HIT  = 4'd2,
    PERF_DL1MISS = 4'd3,
    PERF_IL1HIT  = 4'd4,
    PERF_IL1MISS = 4'd5,
    PERF_BPRED   = 4'd6,
    PERF_BMISPRED = 4'd7,
    PERF_STALL   = 4'd8
  } perf_chan_e;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_CLR  = 2'd2
  } cnt_op_e;

  function automatic logic cnt_fire(input logic ev, input logic en, input logic frz);
    return ev & en & ~frz;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Event, control and read-port bundle between the datapath and the counter bank.
interface perf_counter_bank_if #(
  parameter int NUM_CNT   = 9,
  parameter int CNT_WIDTH = 16,
  parameter int IDX_WIDTH = 4
);

  logic [NUM_CNT-1:0]   event_vec;
  logic [NUM_CNT-1:0]   en_vec;
  logic                 freeze;
  logic [NUM_CNT-1:0]   clr_vec;
  logic                 snap;
  logic                 rd_req;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic                 rd_shadow;
  logic                 rd_resp;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 rd_err;
  logic [NUM_CNT-1:0]   ovf_vec;

  modport master (
    output event_vec, en_vec, freeze, clr_vec, snap, rd_req, rd_idx, rd_shadow,
    input  rd_resp, rd_data, rd_err, ovf_vec
  );

  modport slave (
    input  event_vec, en_vec, freeze, clr_vec, snap, rd_req, rd_idx, rd_shadow,
    output rd_resp, rd_data, rd_err, ovf_vec
  );

endinterface

// File: rtl/perf_counter_bank_counter.sv
// Single counter channel: wrap or saturate increment, sticky overflow,
// and a clear that wins over a same-cycle increment.
module perf_counter
  import perf_counter_bank_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf
);

  cnt_op_e              op_s;
  logic                 at_max_s;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 ovf_r;

  assign at_max_s = &count_r;

  // Operation select: clear has priority over increment.
  always_comb begin
    op_s = CNT_HOLD;
    if (clr) begin
      op_s = CNT_CLR;
    end else if (inc) begin
      op_s = CNT_INC;
    end else begin
      op_s = CNT_HOLD;
    end
  end

  // Count register and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_WIDTH{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      case (op_s)
        CNT_CLR: begin
          count_r <= {CNT_WIDTH{1'b0}};
          ovf_r   <= 1'b0;
        end
        CNT_INC: begin
          if (at_max_s) begin
            ovf_r   <= 1'b1;
            count_r <= (SATURATE != 0) ? count_r : {CNT_WIDTH{1'b0}};
          end else begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          count_r <= count_r;
          ovf_r   <= ovf_r;
        end
      endcase
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters with a snapshot shadow bank and a
// one-cycle-latency registered read port.
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int NUM_CNT   = PERF_NUM_CNT,
  parameter int CNT_WIDTH = PERF_CNT_WIDTH,
  parameter int SATURATE  = 0,
  parameter int IDX_WIDTH = PERF_IDX_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  perf_counter_bank_if.slave bus
);

  logic [CNT_WIDTH-1:0] live_s   [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow_r [NUM_CNT];
  logic [NUM_CNT-1:0]   inc_s;
  logic [NUM_CNT-1:0]   ovf_s;
  logic [NUM_CNT-1:0]   hit_s;
  logic [CNT_WIDTH-1:0] sel_data_s;
  logic                 in_range_s;
  logic                 rd_resp_r;
  logic [CNT_WIDTH-1:0] rd_data_r;
  logic                 rd_err_r;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_chan
    assign inc_s[i] = cnt_fire(bus.event_vec[i], bus.en_vec[i], bus.freeze);
    assign hit_s[i] = (int'(bus.rd_idx) == i);

    perf_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_s[i]),
      .clr   (bus.clr_vec[i]),
      .count (live_s[i]),
      .ovf   (ovf_s[i])
    );
  end

  // Shadow bank captures pre-edge live values, so clear/increment on the
  // same edge do not leak into the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else if (bus.snap) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_r[i] <= live_s[i];
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_r[i] <= shadow_r[i];
      end
    end
  end

  // One-hot AND-OR read mux; an index with no hit yields zero data.
  always_comb begin
    sel_data_s = {CNT_WIDTH{1'b0}};
    in_range_s = |hit_s;
    for (int i = 0; i < NUM_CNT; i++) begin
      sel_data_s = sel_data_s |
                   ({CNT_WIDTH{hit_s[i]}} & (bus.rd_shadow ? shadow_r[i] : live_s[i]));
    end
  end

  // Registered read response; data and error hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_resp_r <= 1'b0;
      rd_data_r <= {CNT_WIDTH{1'b0}};
      rd_err_r  <= 1'b0;
    end else if (bus.rd_req) begin
      rd_resp_r <= 1'b1;
      rd_data_r <= sel_data_s;
      rd_err_r  <= ~in_range_s;
    end else begin
      rd_resp_r <= 1'b0;
      rd_data_r <= rd_data_r;
      rd_err_r  <= rd_err_r;
    end
  end

  assign bus.rd_resp = rd_resp_r;
  assign bus.rd_data = rd_data_r;
  assign bus.rd_err  = rd_err_r;
  assign bus.ovf_vec = ovf_s;

endmodule
